alu_cmd_queue: RTL and testbench

- Command buffer that sits directly upstream of the ALU.
- Accepts {opcode, operandA, operandB} commands from the host side through a valid/ready handshake and stores them in a circular FIFO.
- Issues one command at a time to the ALU, waits a fixed ALU latency, then captures the 8-bit ALU result.
- Presents the captured result downstream through a second valid/ready handshake.

---
 rtl/alu_cmd_queue.sv | 142 ++++++++++++++
 tb/tb_alu_cmd_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// Command queue feeding a fixed-latency ALU: buffers host commands in a circular
// FIFO, issues them one at a time and holds each captured result for a downstream handshake.
module alu_cmd_queue #(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_opcode,
  input  logic [15:0]             cmd_operands,
  output logic [2:0]              alu_opcode,
  output logic [15:0]             alu_operands,
  output logic                    alu_start,
  input  logic [7:0]              alu_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [7:0]              res_data,
  output logic [2:0]              res_opcode,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [PW:0]   FULL_LVL = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAT_LD   = CW'(ALU_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [15:0] operands;
  } cmd_t;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          alu_cmd_q, alu_cmd_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [2:0]    res_opcode_q, res_opcode_d;
  cmd_t          mem_q [DEPTH];

  logic wr_en;
  logic pop;

  assign cmd_ready = (level_q != FULL_LVL);
  assign wr_en     = cmd_valid && cmd_ready;
  // Pop looks at the registered level, so a fresh write is never popped in its own cycle.
  assign pop       = (state_q == IDLE) && (level_q != '0) && !res_valid_q;

  // NOTE: storage array has no reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{opcode: cmd_opcode, operands: cmd_operands};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      alu_cmd_q    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      alu_cmd_q    <= alu_cmd_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_opcode_q <= res_opcode_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    alu_cmd_d    = alu_cmd_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_opcode_d = res_opcode_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);

    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + (PW + 1)'(1);
      2'b01:   level_d = level_q - (PW + 1)'(1);
      default: level_d = level_q;
    endcase

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          alu_cmd_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PW'(1);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LD;
        state_d = WAIT;
      end
      WAIT: begin
        // No issue happens while a result is pending, so capture never overwrites one.
        if (cnt_q == CW'(1)) begin
          res_valid_d  = 1'b1;
          res_data_d   = alu_result;
          res_opcode_d = alu_cmd_q.opcode;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_start    = (state_q == ISSUE);
  assign alu_opcode   = alu_cmd_q.opcode;
  assign alu_operands = alu_cmd_q.operands;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_opcode   = res_opcode_q;
  assign level        = level_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue: a latency-1 instance for queueing/ordering and
// a latency-3 instance for capture timing and mid-operation reset.
module tb_alu_cmd_queue;

  localparam int DEPTH = 8;
  localparam int LAT3  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_opcode = '0;
  logic [15:0] cmd_operands = '0;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_operands;
  logic        alu_start;
  logic [7:0]  alu_result;
  logic        res_valid, res_ready = 1'b0;
  logic [7:0]  res_data;
  logic [2:0]  res_opcode;
  logic [3:0]  level;

  logic        cmd_valid3 = 1'b0, cmd_ready3;
  logic [2:0]  cmd_opcode3 = '0;
  logic [15:0] cmd_operands3 = '0;
  logic [2:0]  alu_opcode3;
  logic [15:0] alu_operands3;
  logic        alu_start3;
  logic [7:0]  alu_result3;
  logic        res_valid3, res_ready3 = 1'b0;
  logic [7:0]  res_data3;
  logic [2:0]  res_opcode3;
  logic [3:0]  level3;

  alu_cmd_queue #(.DEPTH(DEPTH), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operands(cmd_operands),
    .alu_opcode(alu_opcode), .alu_operands(alu_operands),
    .alu_start(alu_start), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opcode(res_opcode), .level(level)
  );

  alu_cmd_queue #(.DEPTH(DEPTH), .ALU_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_opcode(cmd_opcode3), .cmd_operands(cmd_operands3),
    .alu_opcode(alu_opcode3), .alu_operands(alu_operands3),
    .alu_start(alu_start3), .alu_result(alu_result3),
    .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_opcode(res_opcode3), .level(level3)
  );

  // External ALU model (not the DUT): 2 is A+B as used in the first test.
  function automatic logic [7:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_operands[15:8], alu_operands[7:0]);

  // The latency-3 ALU drives a valid result only in the last cycle before the capture edge.
  int since3 = 100;
  always @(posedge clk) since3 <= alu_start3 ? 0 : since3 + 1;
  assign alu_result3 = (since3 == LAT3 - 1) ?
                       alu_f(alu_opcode3, alu_operands3[15:8], alu_operands3[7:0]) : 8'hEE;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [20];
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push(int i);
    cmd_valid    = 1'b1;
    cmd_opcode   = tbl[i].op;
    cmd_operands = {tbl[i].a, tbl[i].b};
    @(negedge clk);
    cmd_valid    = 1'b0;
  endtask

  task automatic push3(logic [2:0] op, logic [15:0] operands);
    cmd_valid3    = 1'b1;
    cmd_opcode3   = op;
    cmd_operands3 = operands;
    @(negedge clk);
    cmd_valid3    = 1'b0;
  endtask

  // Collects results first..last in order; rnd applies a random res_ready each cycle.
  task automatic drain(int first, int last, bit rnd);
    int idx = first;
    int guard = 0;
    while (idx <= last && guard < 500) begin
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_valid && res_ready) begin
        check($sformatf("res_data[%0d]", idx), 32'(res_data), 32'(tbl[idx].exp));
        check($sformatf("res_opcode[%0d]", idx), 32'(res_opcode), 32'(tbl[idx].op));
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    res_ready = 1'b0;
    check("drain_count", 32'(idx), 32'(last + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int starts;
    int n;
    int unstable;
    int extra;
    logic [15:0] oper_hold;
    logic [2:0]  op_hold;

    tbl[0]  = '{3'd2, 8'h05, 8'h03, 8'h08};
    tbl[1]  = '{3'd0, 8'hF0, 8'h3C, 8'h30};
    tbl[2]  = '{3'd1, 8'hF0, 8'h0F, 8'hFF};
    tbl[3]  = '{3'd3, 8'h10, 8'h01, 8'h0F};
    tbl[4]  = '{3'd4, 8'hAA, 8'h55, 8'hFF};
    tbl[5]  = '{3'd2, 8'hFF, 8'h01, 8'h00};
    tbl[6]  = '{3'd3, 8'h00, 8'h01, 8'hFF};
    tbl[7]  = '{3'd5, 8'h12, 8'h34, 8'h12};
    tbl[8]  = '{3'd2, 8'h20, 8'h22, 8'h42};
    tbl[9]  = '{3'd0, 8'h0F, 8'h0A, 8'h0A};
    tbl[10] = '{3'd1, 8'h80, 8'h01, 8'h81};
    tbl[11] = '{3'd4, 8'h3C, 8'h0F, 8'h33};
    tbl[12] = '{3'd3, 8'h50, 8'h20, 8'h30};
    tbl[13] = '{3'd6, 8'h77, 8'h00, 8'h77};
    tbl[14] = '{3'd7, 8'h01, 8'h99, 8'h01};
    tbl[15] = '{3'd2, 8'h7F, 8'h01, 8'h80};
    tbl[16] = '{3'd4, 8'hFF, 8'h0F, 8'hF0};
    tbl[17] = '{3'd1, 8'h00, 8'h00, 8'h00};
    tbl[18] = '{3'd0, 8'hFF, 8'hFF, 8'hFF};
    tbl[19] = '{3'd2, 8'h11, 8'h22, 8'h33};

    // Reset values while rst is held low.
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(level), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_alu_start", 32'(alu_start), 0);
    check("rst_alu_opcode", 32'(alu_opcode), 0);
    check("rst_alu_operands", 32'(alu_operands), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_opcode", 32'(res_opcode), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);

    // Single command: one alu_start pulse, result three edges after the write.
    push(0);
    k = 1;
    starts = 0;
    while (!res_valid && k < 20) begin
      if (alu_start) begin
        starts++;
        check("first_alu_operands", 32'(alu_operands), 32'h0503);
        check("first_alu_opcode", 32'(alu_opcode), 2);
      end
      @(negedge clk);
      k++;
    end
    check("first_latency", 32'(k - 1), 3);
    check("first_start_pulses", 32'(starts), 1);
    check("first_res_data", 32'(res_data), 32'h08);
    check("first_res_opcode", 32'(res_opcode), 2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("first_res_cleared", 32'(res_valid), 0);

    // Fill: one command in flight plus eight stored, then an ignored push while full.
    for (int i = 1; i <= 9; i++) push(i);
    check("full_level", 32'(level), 8);
    check("full_cmd_ready", 32'(cmd_ready), 0);
    push(10);
    check("full_ignored_level", 32'(level), 8);
    repeat (3) @(negedge clk);
    check("stall_res_valid", 32'(res_valid), 1);
    check("stall_res_data", 32'(res_data), 32'(tbl[1].exp));
    check("stall_level", 32'(level), 8);
    check("stall_no_issue", 32'(alu_start), 0);
    drain(1, 9, 1'b0);
    repeat (4) @(negedge clk);
    check("drained_res_valid", 32'(res_valid), 0);
    check("drained_level", 32'(level), 0);

    // Level DEPTH-1: simultaneous push and pop keeps the level.
    for (int i = 10; i <= 17; i++) push(i);
    check("lvl7_level", 32'(level), 7);
    check("lvl7_res_valid", 32'(res_valid), 1);
    check("lvl7_res_data", 32'(res_data), 32'(tbl[10].exp));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("lvl7_pending_cleared", 32'(res_valid), 0);
    check("lvl7_before_pushpop", 32'(level), 7);
    push(18);
    check("pushpop_level", 32'(level), 7);
    check("pushpop_issued", 32'(alu_start), 1);
    push(19);
    check("refull_level", 32'(level), 8);
    check("refull_cmd_ready", 32'(cmd_ready), 0);
    push(0);
    check("refull_ignored_level", 32'(level), 8);

    // Pointers have wrapped; drain with random back-pressure in issue order.
    drain(11, 19, 1'b1);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) extra++;
    end
    check("no_duplicate_results", 32'(extra), 0);
    check("wrap_final_level", 32'(level), 0);

    // Latency-3 instance: capture timing and operand stability during WAIT.
    push3(3'd2, 16'h1234);
    n = -1;
    starts = 0;
    unstable = 0;
    k = 0;
    op_hold = '0;
    oper_hold = '0;
    while (!res_valid3 && k < 50) begin
      if (alu_start3) begin
        starts++;
        n = 0;
        op_hold = alu_opcode3;
        oper_hold = alu_operands3;
      end else if (n >= 0) begin
        n++;
        if (alu_operands3 !== oper_hold || alu_opcode3 !== op_hold) unstable++;
      end
      @(negedge clk);
      k++;
    end
    check("lat3_cycles_after_start", 32'(n), LAT3);
    check("lat3_start_pulses", 32'(starts), 1);
    check("lat3_operands_stable", 32'(unstable), 0);
    check("lat3_res_data", 32'(res_data3), 32'h46);
    check("lat3_res_opcode", 32'(res_opcode3), 2);
    res_ready3 = 1'b1;
    @(negedge clk);
    res_ready3 = 1'b0;

    // Reset during WAIT with four entries queued.
    push3(3'd2, 16'h0101);
    push3(3'd1, 16'h0202);
    push3(3'd0, 16'h0303);
    push3(3'd4, 16'h0404);
    push3(3'd3, 16'h0505);
    check("midrst_level_before", 32'(level3), 4);
    check("midrst_no_result_yet", 32'(res_valid3), 0);
    rst = 1'b0;
    #1;
    check("midrst_level", 32'(level3), 0);
    check("midrst_res_valid", 32'(res_valid3), 0);
    check("midrst_alu_start", 32'(alu_start3), 0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid3 || alu_start3) extra++;
    end
    check("midrst_no_activity", 32'(extra), 0);
    check("midrst_level_after", 32'(level3), 0);
    check("midrst_cmd_ready", 32'(cmd_ready3), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
